// File: rtl/alu_seq_if.sv
// Operand/result bundle between the issuing controller, the ALU and the result consumer.
// The master side issues operations and consumes results; the slave side is the ALU.
// Both channels use valid/ready flow control.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [3:0]       op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] alu_o;
  logic             carry_o;
  logic             ovf_o;
  logic             zero_o;
  logic             neg_o;
  logic             err_o;

  modport master (
    output in_valid_i, a_i, b_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_o, carry_o, ovf_o, zero_o, neg_o, err_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_o, carry_o, ovf_o, zero_o, neg_o, err_o
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and an iterative shift-add multiplier.
// Latency: 1 cycle for non-MUL ops, WIDTH cycles for MUL (result valid after edge N+WIDTH).
// Backpressure: a held result stalls intake (in_ready low) until consumed; in_ready is low while multiplying.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk_i,
  input logic       rst_ni,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_EQL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_LTU = 4'd9;
  localparam logic [3:0] OP_LT  = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Result and flag registers
  logic [WIDTH-1:0] res_q;
  logic             carry_q, ovf_q, zero_q, neg_q, err_q;

  // Multiplier working registers
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_sum;

  // Combinational single-cycle result
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d, err_d;

  // FSM controls
  logic in_ready, accept, load_res, start_mul, mul_done;

  assign in_ready = rst_ni & ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready_i));
  assign accept   = bus.in_valid_i & in_ready;

  assign sum  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign diff = {1'b0, bus.a_i} - {1'b0, bus.b_i};
  assign sh   = bus.b_i[SHW-1:0];

  // One partial product per cycle: add the shifted multiplicand when the current multiplier bit is set
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Opcode decode and single-cycle datapath; reserved opcodes yield 0 with err set
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (bus.op_i)
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (bus.a_i[WIDTH-1] == bus.b_i[WIDTH-1]) && (sum[WIDTH-1] != bus.a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (bus.a_i[WIDTH-1] != bus.b_i[WIDTH-1]) && (diff[WIDTH-1] != bus.a_i[WIDTH-1]);
      end
      OP_SLL: res_d = bus.a_i << sh;
      OP_SRL: res_d = bus.a_i >> sh;
      OP_AND: res_d = bus.a_i & bus.b_i;
      OP_OR:  res_d = bus.a_i | bus.b_i;
      OP_XOR: res_d = bus.a_i ^ bus.b_i;
      OP_EQL: res_d = {{(WIDTH-1){1'b0}}, bus.a_i == bus.b_i};
      OP_SRA: res_d = $signed(bus.a_i) >>> sh;
      OP_LTU: res_d = {{(WIDTH-1){1'b0}}, bus.a_i < bus.b_i};
      OP_LT:  res_d = {{(WIDTH-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)};
      OP_MUL: res_d = '0;
      default: err_d = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    load_res  = 1'b0;
    start_mul = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (bus.op_i == OP_MUL) begin
            start_mul = 1'b1;
            state_d   = S_BUSY;
          end else begin
            load_res = 1'b1;
            state_d  = S_DONE;
          end
        end else if ((state_q == S_DONE) && bus.out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          mul_done = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers and multiplier iteration; reset discards any operation in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (load_res) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= (res_d == '0);
        neg_q   <= res_d[WIDTH-1];
        err_q   <= err_d;
      end
      if (start_mul) begin
        mcand_q  <= {{WIDTH{1'b0}}, bus.a_i};
        mplier_q <= bus.b_i;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == S_BUSY) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (mul_done) begin
        res_q   <= acc_sum[WIDTH-1:0];
        carry_q <= |acc_sum[2*WIDTH-1:WIDTH];
        ovf_q   <= 1'b0;
        zero_q  <= (acc_sum[WIDTH-1:0] == '0);
        neg_q   <= acc_sum[WIDTH-1];
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == S_DONE);
  assign bus.alu_o       = res_q;
  assign bus.carry_o     = carry_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.zero_o      = zero_q;
  assign bus.neg_o       = neg_q;
  assign bus.err_o       = err_q;

endmodule
